// File: rtl/axi_w_dest_sequencer.sv
// W-channel destination sequencer: queues decoder destinations, steers W beats, counts outstanding writes.
// Optional same-cycle fall-through from push to routing when AXI_W_SEQ_BYPASS_EN is defined.
module axi_w_dest_sequencer #(
    parameter int N_INIT_PORT     = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_DEST_i,
    input  logic [N_INIT_PORT-1:0] DEST_i,
    output logic                   grant_FIFO_DEST_o,
    input  logic                   wvalid_i,
    input  logic                   wlast_i,
    output logic                   wready_o,
    output logic [N_INIT_PORT-1:0] wvalid_o,
    input  logic [N_INIT_PORT-1:0] wready_i,
    input  logic                   incr_req_i,
    input  logic                   decr_req_i,
    output logic                   full_counter_o,
    output logic                   outstanding_trans_o,
    input  logic                   handle_error_i,
    output logic                   wdata_error_completed_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        ST_ROUTE     = 2'd0,
        ST_SINK      = 2'd1,
        ST_SINK_DONE = 2'd2
    } state_e;

    logic [N_INIT_PORT-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [OUT_W-1:0]       out_cnt_q, out_cnt_d;
    state_e                 state_q, state_d;

    logic                   fifo_empty_s;
    logic                   fifo_full_s;
    logic                   push_ok_s;
    logic                   fifo_write_s;
    logic                   fifo_pop_s;
    logic                   route_pop_s;
    logic                   bypass_s;
    logic [N_INIT_PORT-1:0] route_dest_s;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + PTR_W'(1);
    endfunction

    assign fifo_empty_s = (fifo_cnt_q == CNT_W'(0));
    assign fifo_full_s  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));

    assign grant_FIFO_DEST_o       = ~fifo_full_s;
    assign full_counter_o          = (out_cnt_q == OUT_W'(MAX_OUTSTANDING));
    assign outstanding_trans_o     = (out_cnt_q != OUT_W'(0));
    assign wdata_error_completed_o = (state_q == ST_SINK_DONE);

    // Select the destination W beats are currently steered to (zero when none).
    always_comb begin
        route_dest_s = '0;
        bypass_s     = 1'b0;
        if (state_q != ST_ROUTE) begin
            route_dest_s = '0;
        end else if (!fifo_empty_s) begin
            route_dest_s = fifo_q[rd_ptr_q];
        end
`ifdef AXI_W_SEQ_BYPASS_EN
        else if (push_DEST_i) begin
            route_dest_s = DEST_i;
            bypass_s     = 1'b1;
        end
`endif
        else begin
            route_dest_s = '0;
        end
    end

    // FSM next state and W handshake outputs.
    always_comb begin
        state_d     = state_q;
        wvalid_o    = '0;
        wready_o    = 1'b0;
        route_pop_s = 1'b0;
        case (state_q)
            ST_ROUTE: begin
                wvalid_o    = {N_INIT_PORT{wvalid_i}} & route_dest_s;
                wready_o    = |(wready_i & route_dest_s);
                route_pop_s = wvalid_i & wready_o & wlast_i;
                // An error with bursts still queued waits until they drain.
                if (handle_error_i && fifo_empty_s) begin
                    state_d = ST_SINK;
                end else begin
                    state_d = ST_ROUTE;
                end
            end
            ST_SINK: begin
                wready_o = 1'b1;
                if (wvalid_i && wlast_i) begin
                    state_d = ST_SINK_DONE;
                end else begin
                    state_d = ST_SINK;
                end
            end
            ST_SINK_DONE: begin
                if (!handle_error_i) begin
                    state_d = ST_ROUTE;
                end else begin
                    state_d = ST_SINK_DONE;
                end
            end
            default: begin
                state_d = ST_ROUTE;
            end
        endcase
    end

    // FIFO bookkeeping; a bypassed burst finishing in its push cycle is never stored.
    always_comb begin
        push_ok_s    = push_DEST_i & ~fifo_full_s;
        fifo_pop_s   = route_pop_s & ~bypass_s;
        fifo_write_s = push_ok_s & ~(bypass_s & route_pop_s);
        wr_ptr_d     = fifo_write_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = fifo_pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({fifo_write_s, fifo_pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Saturating outstanding-write counter.
    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({incr_req_i, decr_req_i})
            2'b10: begin
                if (out_cnt_q != OUT_W'(MAX_OUTSTANDING)) begin
                    out_cnt_d = out_cnt_q + OUT_W'(1);
                end else begin
                    out_cnt_d = out_cnt_q;
                end
            end
            2'b01: begin
                if (out_cnt_q != OUT_W'(0)) begin
                    out_cnt_d = out_cnt_q - OUT_W'(1);
                end else begin
                    out_cnt_d = out_cnt_q;
                end
            end
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // Destination storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (fifo_write_s) begin
            fifo_q[wr_ptr_q] <= DEST_i;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
            state_q    <= ST_ROUTE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            out_cnt_q  <= out_cnt_d;
            state_q    <= state_d;
        end
    end

endmodule
